aes_key_expansion_iter: RTL

Iterative, multi-key-length AES key expansion engine: generates the full round-key schedule for AES-128, AES-192 or AES-256 at one 32-bit word per clock and holds it in an internal round-key store. A random-access read port serves the cipher datapath. A per-round valid mask lets rounds start as soon as their key exists. It is the area-reduced, mode-selectable successor to the unrolled 128-bit round-key chain and sits between key load and the round pipeline.

---
 rtl/aes_key_expansion_iter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expansion_iter.sv
// rtl/aes_key_expansion_iter.sv - iterative AES-128/192/256 key schedule engine with random-access round-key store

// Byte substitution: GF(2^8) inverse computed as x^254, then the AES affine transform
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

  // Addition chain to x^254 (zero maps to zero), then affine map with constant 0x63
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, in_byte);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, in_byte);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, in_byte);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, in_byte);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, in_byte);
    inv  = gf_mul(x127, x127);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_key_expansion_iter #(
  parameter int KEY_MAX  = 256,
  parameter int RK_DEPTH = KEY_MAX/32 + 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [KEY_MAX-1:0]  cipher_key,
  output logic                ready,
  output logic                done,
  output logic                err,
  output logic                key_valid,
  output logic [RK_DEPTH-1:0] rk_valid,
  input  logic [3:0]          rk_addr,
  output logic [127:0]        rk_data
);

  localparam int KW = KEY_MAX/32;
  localparam int SW = 4*RK_DEPTH;
  localparam logic [4:0] DEPTH5 = 5'(RK_DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  logic [0:0]          state;
  logic [1:0]          mode;
  logic [5:0]          idx;
  logic [2:0]          kcnt;
  logic [7:0]          rcon;
  logic [31:0]         store [0:SW-1];
  logic [31:0]         win [0:7];

  logic [31:0]         key_w [0:7];
  logic [31:0]         win_init [0:7];
  logic [RK_DEPTH-1:0] rkv_init;
  logic [3:0]          nk_new;
  logic                legal;
  logic [2:0]          nk_last;
  logic [5:0]          last_idx;
  logic [4:0]          rd_limit;
  logic [31:0]         prev_w, far_w, sub_in, sub_out, temp, new_w;

  assign ready  = (state == ST_IDLE);
  assign nk_new = 4'd4 + {1'b0, key_len, 1'b0};

  // Split the left-aligned key bus into 32-bit words, w[0] from the MSBs
  always_comb begin
    for (int j = 0; j < 8; j++) key_w[j] = 32'h0;
    for (int j = 0; j < KW; j++) key_w[j] = cipher_key[KEY_MAX-1-32*j -: 32];
  end

  // Mode legality plus window preload (newest word at index 0) and initial round-valid mask
  always_comb begin
    case (key_len)
      2'd0:    legal = (KEY_MAX >= 128);
      2'd1:    legal = (KEY_MAX >= 192);
      2'd2:    legal = (KEY_MAX >= 256);
      default: legal = 1'b0;
    endcase
    for (int j = 0; j < 8; j++) win_init[j] = 32'h0;
    rkv_init    = '0;
    rkv_init[0] = 1'b1;
    case (key_len)
      2'd0:    for (int j = 0; j < 4; j++) win_init[j] = key_w[3-j];
      2'd1:    for (int j = 0; j < 6; j++) win_init[j] = key_w[5-j];
      default: begin
        for (int j = 0; j < 8; j++) win_init[j] = key_w[7-j];
        rkv_init[1] = 1'b1;
      end
    endcase
  end

  // Per-mode constants for the latched mode: Nk-1, final word index, round count + 1
  always_comb begin
    case (mode)
      2'd0:    begin nk_last = 3'd3; last_idx = 6'd43; rd_limit = 5'd11; end
      2'd1:    begin nk_last = 3'd5; last_idx = 6'd51; rd_limit = 5'd13; end
      default: begin nk_last = 3'd7; last_idx = 6'd59; rd_limit = 5'd15; end
    endcase
  end

  assign prev_w = win[0];
  assign sub_in = (kcnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_sbox u_sbox0 (.in_byte(sub_in[31:24]), .out_byte(sub_out[31:24]));
  aes_sbox u_sbox1 (.in_byte(sub_in[23:16]), .out_byte(sub_out[23:16]));
  aes_sbox u_sbox2 (.in_byte(sub_in[15:8]),  .out_byte(sub_out[15:8]));
  aes_sbox u_sbox3 (.in_byte(sub_in[7:0]),   .out_byte(sub_out[7:0]));

  // Next schedule word from w[i-1] and w[i-Nk]; kcnt tracks i mod Nk
  always_comb begin
    case (mode)
      2'd0:    far_w = win[3];
      2'd1:    far_w = win[5];
      default: far_w = win[7];
    endcase
    if (kcnt == 3'd0)                    temp = sub_out ^ {rcon, 24'h0};
    else if (mode == 2'd2 && kcnt == 3'd4) temp = sub_out;
    else                                 temp = prev_w;
    new_w = far_w ^ temp;
  end

  // Control, sliding window and store: load on accepted start, then one word per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode      <= 2'd0;
      idx       <= 6'd0;
      kcnt      <= 3'd0;
      rcon      <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
      key_valid <= 1'b0;
      rk_valid  <= '0;
      for (int j = 0; j < 8; j++) win[j] <= 32'h0;
      for (int j = 0; j < SW; j++) store[j] <= 32'h0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_IDLE) begin
        if (start && !legal) begin
          err <= 1'b1;
        end else if (start) begin
          state     <= ST_EXPAND;
          mode      <= key_len;
          idx       <= {2'b00, nk_new};
          kcnt      <= 3'd0;
          rcon      <= 8'h01;
          key_valid <= 1'b0;
          rk_valid  <= rkv_init;
          for (int j = 0; j < 8; j++) win[j] <= win_init[j];
          for (int j = 0; j < 8; j++) store[j] <= (4'(j) < nk_new) ? key_w[j] : 32'h0;
          for (int j = 8; j < SW; j++) store[j] <= 32'h0;
        end
      end else begin
        store[idx] <= new_w;
        win[0]     <= new_w;
        for (int j = 1; j < 8; j++) win[j] <= win[j-1];
        for (int r = 0; r < RK_DEPTH; r++) begin
          if (idx[1:0] == 2'b11 && idx[5:2] == r[3:0]) rk_valid[r] <= 1'b1;
        end
        if (kcnt == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        kcnt <= (kcnt == nk_last) ? 3'd0 : kcnt + 3'd1;
        idx  <= idx + 6'd1;
        if (idx == last_idx) begin
          state     <= ST_IDLE;
          done      <= 1'b1;
          key_valid <= 1'b1;
        end
      end
    end
  end

  // Registered read port; addresses beyond the latched mode's rounds read as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_data <= 128'h0;
    end else if ({1'b0, rk_addr} >= rd_limit || {1'b0, rk_addr} >= DEPTH5) begin
      rk_data <= 128'h0;
    end else begin
      rk_data <= {store[{rk_addr, 2'b00}], store[{rk_addr, 2'b01}],
                  store[{rk_addr, 2'b10}], store[{rk_addr, 2'b11}]};
    end
  end

endmodule
